mc_ctrl_fsm: RTL and testbench

//  Next-generation multi-cycle MIPS control FSM. Drives datapath muxes/enables per state, like the

---
 rtl/mc_ctrl_fsm_if.sv | 58 +++++
 rtl/mc_ctrl_fsm.sv | 257 +++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm_if : IR/flag inputs, MIO handshake and datapath controls. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mc_ctrl_fsm_if #(
  parameter int STATE_W = 5,
  parameter int ALUOP_W = 4
);
  logic [31:0]        inst_in;
  logic               zero;
  logic               overflow;
  logic               mem_ready;
`ifdef MCTRL_IRQ_EN
  logic               irq;
`endif
  logic               MemRead;
  logic               MemWrite;
  logic               CPU_MIO;
  logic               IorD;
  logic               IRWrite;
  logic               RegWrite;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               Branch;
  logic               sign;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [2:0]         PCSource;
  logic [ALUOP_W-1:0] ALU_operation;
  logic               EPCWrite;
  logic [2:0]         exc_cause;
  logic [STATE_W-1:0] state_out;

  modport master (
    input  inst_in, zero, overflow, mem_ready,
`ifdef MCTRL_IRQ_EN
    input  irq,
`endif
    output MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, PCWrite,
           PCWriteCond, Branch, sign, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, ALU_operation, EPCWrite, exc_cause, state_out
  );

  modport slave (
    output inst_in, zero, overflow, mem_ready,
`ifdef MCTRL_IRQ_EN
    output irq,
`endif
    input  MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, PCWrite,
           PCWriteCond, Branch, sign, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
           PCSource, ALU_operation, EPCWrite, exc_cause, state_out
  );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm : multi-cycle MIPS control FSM with MIO wait states, bus timeout
// and precise exceptions. Optional interrupt entry: MCTRL_IRQ_EN.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mc_ctrl_fsm #(
  parameter int STATE_W     = 5,
  parameter int ALUOP_W     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  mc_ctrl_fsm_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0] c_cause_ovf = 3'd1;
  localparam logic [2:0] c_cause_bus = 3'd2;
  localparam logic [2:0] c_cause_ill = 3'd3;
  localparam logic [2:0] c_cause_irq = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IF = STATE_W'(0),  S_ID = STATE_W'(1),   S_MAC = STATE_W'(2),    S_MAR = STATE_W'(3),
    S_WB = STATE_W'(4),  S_MAW = STATE_W'(5),  S_EXE = STATE_W'(6),    S_RTYPE = STATE_W'(7),
    S_BR = STATE_W'(8),  S_J = STATE_W'(9),    S_JAL = STATE_W'(10),   S_JR = STATE_W'(11),
    S_EXEI = STATE_W'(12), S_LUI = STATE_W'(13), S_RTYPEI = STATE_W'(14), S_EXC = STATE_W'(15)
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_cause;

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_mem_state;
  logic       w_tmo;
  logic       w_funct_ovf;
  logic       w_irq;
  logic       w_unused;

  assign w_op        = bus.inst_in[31:26];
  assign w_funct     = bus.inst_in[5:0];
  assign w_mem_state = (r_state == S_IF) || (r_state == S_MAR) || (r_state == S_MAW);
  assign w_tmo       = (r_cnt == c_cnt_last);
  assign w_funct_ovf = (w_funct == 6'b100000) || (w_funct == 6'b100010);
  assign w_unused    = ^bus.inst_in[25:6];
`ifdef MCTRL_IRQ_EN
  assign w_irq = bus.irq;
`else
  assign w_irq = 1'b0;
`endif

  function automatic logic [ALUOP_W-1:0] alu_r(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001: alu_r = ALUOP_W'(2);
      6'b100010, 6'b100011: alu_r = ALUOP_W'(6);
      6'b100100:            alu_r = ALUOP_W'(0);
      6'b100101:            alu_r = ALUOP_W'(1);
      6'b100110:            alu_r = ALUOP_W'(3);
      6'b100111:            alu_r = ALUOP_W'(4);
      6'b101010:            alu_r = ALUOP_W'(7);
      6'b000000:            alu_r = ALUOP_W'(8);
      6'b000010:            alu_r = ALUOP_W'(5);
      6'b000011:            alu_r = ALUOP_W'(9);
      default:              alu_r = ALUOP_W'(2);
    endcase
  endfunction

  function automatic logic [ALUOP_W-1:0] alu_i(input logic [5:0] op);
    case (op)
      6'b001010: alu_i = ALUOP_W'(7);
      6'b001100: alu_i = ALUOP_W'(0);
      6'b001101: alu_i = ALUOP_W'(1);
      6'b001110: alu_i = ALUOP_W'(3);
      default:   alu_i = ALUOP_W'(2);
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IF;
      r_cnt   <= '0;
      r_cause <= '0;
    end else begin
      // Counter only runs while a memory state is stalled; any exit clears it.
      if (w_mem_state && !bus.mem_ready && !w_tmo) r_cnt <= r_cnt + 1'b1;
      else                                          r_cnt <= '0;

      if (w_mem_state && !bus.mem_ready) begin
        if (w_tmo) begin
          r_state <= S_EXC;
          r_cause <= c_cause_bus;
        end
      end else begin
        case (r_state)
          S_IF:  r_state <= S_ID;
          S_MAR: r_state <= S_WB;
          S_ID: begin
            case (w_op)
              6'b000000:                        r_state <= S_EXE;
              6'b100011, 6'b101011:             r_state <= S_MAC;
              6'b000010:                        r_state <= S_J;
              6'b000011:                        r_state <= S_JAL;
              6'b000100, 6'b000101:             r_state <= S_BR;
              6'b001000, 6'b001010, 6'b001100,
              6'b001101, 6'b001110:             r_state <= S_EXEI;
              6'b001111:                        r_state <= S_LUI;
              default: begin
                r_state <= S_EXC;
                r_cause <= c_cause_ill;
              end
            endcase
          end
          S_MAC: r_state <= bus.inst_in[29] ? S_MAW : S_MAR;
          S_EXE: begin
            if (w_funct_ovf && bus.overflow) begin
              r_state <= S_EXC;
              r_cause <= c_cause_ovf;
            end else begin
              r_state <= (w_funct == 6'b001000) ? S_JR : S_RTYPE;
            end
          end
          S_EXEI: begin
            if ((w_op == 6'b001000) && bus.overflow) begin
              r_state <= S_EXC;
              r_cause <= c_cause_ovf;
            end else begin
              r_state <= S_RTYPEI;
            end
          end
          S_EXC: r_state <= S_IF;
          // Remaining states finish an instruction: the only place irq is taken.
          default: begin
            if (w_irq) begin
              r_state <= S_EXC;
              r_cause <= c_cause_irq;
            end else begin
              r_state <= S_IF;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.MemRead       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.CPU_MIO       = 1'b0;
    bus.IorD          = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.PCWrite       = 1'b0;
    bus.PCWriteCond   = 1'b0;
    bus.Branch        = 1'b0;
    bus.sign          = 1'b0;
    bus.RegDst        = 2'd0;
    bus.MemtoReg      = 2'd0;
    bus.ALUSrcA       = 2'd0;
    bus.ALUSrcB       = 2'd0;
    bus.PCSource      = 3'd0;
    bus.ALU_operation = ALUOP_W'(0);
    bus.EPCWrite      = 1'b0;
    if (reset_n) begin
      case (r_state)
        S_IF: begin
          bus.MemRead       = 1'b1;
          bus.CPU_MIO       = 1'b1;
          bus.ALUSrcB       = 2'd1;
          bus.ALU_operation = ALUOP_W'(2);
          bus.IRWrite       = bus.mem_ready;
          bus.PCWrite       = bus.mem_ready;
        end
        S_ID: begin
          bus.ALUSrcB       = 2'd3;
          bus.sign          = 1'b1;
          bus.ALU_operation = ALUOP_W'(2);
        end
        S_MAC: begin
          bus.ALUSrcA       = 2'd1;
          bus.ALUSrcB       = 2'd2;
          bus.sign          = 1'b1;
          bus.ALU_operation = ALUOP_W'(2);
        end
        S_MAR: begin
          bus.MemRead = 1'b1;
          bus.CPU_MIO = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 2'd1;
        end
        S_MAW: begin
          bus.MemWrite = 1'b1;
          bus.CPU_MIO  = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_EXE: begin
          bus.ALUSrcA       = 2'd1;
          bus.ALU_operation = alu_r(w_funct);
        end
        S_RTYPE: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 2'd1;
        end
        S_BR: begin
          bus.ALUSrcA       = 2'd1;
          bus.ALU_operation = ALUOP_W'(6);
          bus.Branch        = 1'b1;
          bus.PCSource      = 3'd1;
          bus.PCWriteCond   = ((w_op == 6'b000100) &&  bus.zero) ||
                              ((w_op == 6'b000101) && !bus.zero);
        end
        S_J: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 3'd2;
        end
        S_JAL: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 3'd2;
          bus.RegWrite = 1'b1;
          bus.RegDst   = 2'd2;
          bus.MemtoReg = 2'd2;
        end
        S_JR: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 3'd3;
        end
        S_EXEI: begin
          bus.ALUSrcA       = 2'd1;
          bus.ALUSrcB       = 2'd2;
          bus.sign          = (w_op == 6'b001000) || (w_op == 6'b001010);
          bus.ALU_operation = alu_i(w_op);
        end
        S_LUI: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 2'd3;
        end
        S_RTYPEI: bus.RegWrite = 1'b1;
        S_EXC: begin
          bus.EPCWrite = 1'b1;
          bus.PCWrite  = 1'b1;
          bus.PCSource = 3'd4;
        end
        default: ;
      endcase
    end
  end

  assign bus.exc_cause = r_cause;
  assign bus.state_out = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm : directed scoreboard bench for mc_ctrl_fsm.        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mc_ctrl_fsm;
  localparam int TMO = 16;

  localparam int K_STATE = 0, K_CAUSE = 1, K_REGW = 2, K_REGDST = 3, K_MEMRD = 4,
                 K_IORD = 5, K_EPCW = 6, K_PCSRC = 7, K_PCWC = 8, K_IRW = 9,
                 K_PCW = 10, K_MEMWR = 11, K_BRANCH = 12;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0004;
  localparam logic [31:0] I_ADDI = 32'h2022_0005;
  localparam logic [31:0] I_ANDI = 32'h3022_0005;
  localparam logic [31:0] I_BNE  = 32'h1422_0003;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;
  localparam logic [31:0] I_J    = 32'h0800_0010;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.STATE_W(5), .ALUOP_W(4)) bus_if ();

  mc_ctrl_fsm #(.STATE_W(5), .ALUOP_W(4), .TIMEOUT_CYC(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(input int k);
    case (k)
      K_STATE:  observe = 32'(bus_if.state_out);
      K_CAUSE:  observe = 32'(bus_if.exc_cause);
      K_REGW:   observe = 32'(bus_if.RegWrite);
      K_REGDST: observe = 32'(bus_if.RegDst);
      K_MEMRD:  observe = 32'(bus_if.MemRead);
      K_IORD:   observe = 32'(bus_if.IorD);
      K_EPCW:   observe = 32'(bus_if.EPCWrite);
      K_PCSRC:  observe = 32'(bus_if.PCSource);
      K_PCWC:   observe = 32'(bus_if.PCWriteCond);
      K_IRW:    observe = 32'(bus_if.IRWrite);
      K_PCW:    observe = 32'(bus_if.PCWrite);
      K_MEMWR:  observe = 32'(bus_if.MemWrite);
      K_BRANCH: observe = 32'(bus_if.Branch);
      default:  observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic exp_v(input string tag, input int k, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic chk();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.kind);
      checks++;
      assert (o === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic step(input string tag, input int s);
    exp_v(tag, K_STATE, 32'(s));
    chk();
    tick();
  endtask

  // Present an instruction in IF with the fetch completing this cycle.
  task automatic fetch(input string tag, input logic [31:0] inst);
    bus_if.inst_in   = inst;
    bus_if.mem_ready = 1'b1;
    exp_v(tag, K_STATE, 32'd0);
    exp_v(tag, K_IRW, 32'd1);
    exp_v(tag, K_PCW, 32'd1);
    exp_v(tag, K_REGW, 32'd0);
    chk();
    tick();
  endtask

  initial begin
    bus_if.inst_in   = 32'h0;
    bus_if.zero      = 1'b0;
    bus_if.overflow  = 1'b0;
    bus_if.mem_ready = 1'b0;
`ifdef MCTRL_IRQ_EN
    bus_if.irq       = 1'b0;
`endif
    #3;
    exp_v("rst_state", K_STATE, 32'd0);
    exp_v("rst_cause", K_CAUSE, 32'd0);
    exp_v("rst_memrd", K_MEMRD, 32'd0);
    exp_v("rst_pcw", K_PCW, 32'd0);
    chk();
    @(negedge clk);
    reset_n = 1'b1;

    // add: IF ID EXE RTYPE
    fetch("add_if", I_ADD);
    exp_v("add_id_regw", K_REGW, 32'd0);
    step("add_id", 1);
    exp_v("add_exe_regdst", K_REGDST, 32'd0);
    step("add_exe", 6);
    exp_v("add_rt_regw", K_REGW, 32'd1);
    exp_v("add_rt_regdst", K_REGDST, 32'd1);
    step("add_rtype", 7);

    // lw with three wait cycles in MAR
    fetch("lw_if", I_LW);
    step("lw_id", 1);
    step("lw_mac", 2);
    bus_if.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_v("lw_mar_memrd", K_MEMRD, 32'd1);
      exp_v("lw_mar_iord", K_IORD, 32'd1);
      step("lw_mar_wait", 3);
    end
    bus_if.mem_ready = 1'b1;
    step("lw_mar_done", 3);
    exp_v("lw_wb_regw", K_REGW, 32'd1);
    step("lw_wb", 4);

    // IF stalls for the full timeout window
    bus_if.mem_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      exp_v("tmo_if_irw", K_IRW, 32'd0);
      step("tmo_if_wait", 0);
    end
    exp_v("tmo_cause", K_CAUSE, 32'd2);
    exp_v("tmo_epcw", K_EPCW, 32'd1);
    exp_v("tmo_pcsrc", K_PCSRC, 32'd4);
    exp_v("tmo_pcw", K_PCW, 32'd1);
    step("tmo_exc", 15);

    // ready on the last allowed cycle wins over the timeout
    bus_if.inst_in = I_ADD;
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
    end
    fetch("tmo_edge_if", I_ADD);
    step("tmo_edge_id", 1);
    step("tmo_edge_exe", 6);
    step("tmo_edge_rt", 7);

    // addi overflow -> EXC cause 1
    fetch("addi_if", I_ADDI);
    step("addi_id", 1);
    bus_if.overflow = 1'b1;
    exp_v("addi_exei_regw", K_REGW, 32'd0);
    step("addi_exei", 12);
    bus_if.overflow = 1'b0;
    exp_v("addi_cause", K_CAUSE, 32'd1);
    exp_v("addi_exc_regw", K_REGW, 32'd0);
    step("addi_exc", 15);

    // andi ignores overflow
    fetch("andi_if", I_ANDI);
    step("andi_id", 1);
    bus_if.overflow = 1'b1;
    step("andi_exei", 12);
    bus_if.overflow = 1'b0;
    exp_v("andi_rti_regw", K_REGW, 32'd1);
    step("andi_rtypei", 14);

    // add overflow in EXE
    fetch("addov_if", I_ADD);
    step("addov_id", 1);
    bus_if.overflow = 1'b1;
    step("addov_exe", 6);
    bus_if.overflow = 1'b0;
    exp_v("addov_cause", K_CAUSE, 32'd1);
    step("addov_exc", 15);

    // illegal opcode
    fetch("ill_if", I_ILL);
    step("ill_id", 1);
    exp_v("ill_cause", K_CAUSE, 32'd3);
    exp_v("ill_epcw", K_EPCW, 32'd1);
    step("ill_exc", 15);

    // bne / beq condition
    fetch("bne_if", I_BNE);
    step("bne_id", 1);
    bus_if.zero = 1'b0;
    exp_v("bne_pcwc_z0", K_PCWC, 32'd1);
    exp_v("bne_branch", K_BRANCH, 32'd1);
    exp_v("bne_cause_held", K_CAUSE, 32'd3);
    exp_v("bne_state", K_STATE, 32'd8);
    chk();
    bus_if.zero = 1'b1;
    exp_v("bne_pcwc_z1", K_PCWC, 32'd0);
    step("bne_br", 8);
    fetch("beq_if", I_BEQ);
    step("beq_id", 1);
    exp_v("beq_pcwc_z1", K_PCWC, 32'd1);
    step("beq_br", 8);
    bus_if.zero = 1'b0;

    // sw with one wait cycle in MAW
    fetch("sw_if", I_SW);
    step("sw_id", 1);
    step("sw_mac", 2);
    bus_if.mem_ready = 1'b0;
    exp_v("sw_maw_memwr", K_MEMWR, 32'd1);
    step("sw_maw_wait", 5);
    bus_if.mem_ready = 1'b1;
    step("sw_maw_done", 5);

    // jump, with an interrupt taken at its end when enabled
    fetch("j_if", I_J);
    step("j_id", 1);
`ifdef MCTRL_IRQ_EN
    bus_if.irq = 1'b1;
    step("j_j", 9);
    bus_if.irq = 1'b0;
    exp_v("irq_cause", K_CAUSE, 32'd4);
    step("irq_exc", 15);
`else
    step("j_j", 9);
`endif

    // asynchronous reset mid-access
    fetch("rstm_if", I_LW);
    step("rstm_id", 1);
    step("rstm_mac", 2);
    bus_if.mem_ready = 1'b0;
    exp_v("rstm_mar", K_STATE, 32'd3);
    chk();
    #1;
    reset_n = 1'b0;
    exp_v("rstm_state", K_STATE, 32'd0);
    exp_v("rstm_memrd", K_MEMRD, 32'd0);
    exp_v("rstm_cause", K_CAUSE, 32'd0);
    chk();
    @(negedge clk);
    reset_n = 1'b1;
    fetch("rstm_refetch", I_ADD);
    exp_v("rstm_id", K_STATE, 32'd1);
    chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
